// File: rtl/ram_access_master.sv
// ram_access_master
// Requester-side controller for the model computer's RAM port. One request is
// taken at a time over a valid/ready handshake; the controller then drives the
// RAM strobes with the required timing and returns a single response.
//
// Handshake semantics (both request and response channels): a transfer occurs
// on a rising clock edge where valid and ready are both 1. The sender holds
// valid and its payload stable until that edge. A valid presented while ready
// is 0 is not remembered. Ready asserted without valid has no effect.
//
// Timing, with E0 as the accept edge:
//   write: ram_write is high after edges E0 .. E0+WRITE_HOLD-1. It falls at edge
//          E0+WRITE_HOLD, and the response is presented at that same edge.
//   read : ram_read is high after edges E0 .. E0+READ_LATENCY. Edge
//          E0+1+READ_LATENCY captures ram_out into rsp_rdata, drops ram_read
//          and presents the response.

module ram_access_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_HOLD   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    // RAM pins
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    // The wait counter must hold the longer of the two phases. A read waits
    // READ_LATENCY counts after the accept edge. A write waits WRITE_HOLD-1
    // counts after the accept edge.
    localparam int MAX_WAIT = (READ_LATENCY + 1 > WRITE_HOLD) ? (READ_LATENCY + 1) : WRITE_HOLD;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;

    // A request transfers only when the controller is advertising ready.
    assign accept = req_valid && req_ready;

    // Main controller FSM. Every output is a register that this block updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_is_write <= 1'b0;
            rsp_rdata    <= '0;
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            ram_address  <= '0;
            ram_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Address and data are latched only here. They therefore
                    // cannot move while a strobe is high.
                    if (accept) begin
                        req_ready   <= 1'b0;
                        ram_address <= req_addr;
                        ram_data    <= req_wdata;
                        if (req_we) begin
                            ram_write <= 1'b1;
                            wait_cnt  <= CNT_W'(WRITE_HOLD - 1);
                            state     <= WR;
                        end else begin
                            ram_read <= 1'b1;
                            wait_cnt <= CNT_W'(READ_LATENCY);
                            state    <= RD;
                        end
                    end
                end

                WR: begin
                    if (wait_cnt == '0) begin
                        ram_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_is_write <= 1'b1;
                        rsp_rdata    <= '0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                RD: begin
                    // When the counter reaches zero, ram_out has had
                    // READ_LATENCY edges since the RAM first saw the strobe.
                    if (wait_cnt == '0) begin
                        ram_read     <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_is_write <= 1'b0;
                        rsp_rdata    <= ram_out;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                RESP: begin
                    // The payload stays frozen until the requester takes it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the RAM port, checked on every clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ram_read && ram_write))
                else $error("ram_read and ram_write asserted together");
            assert (!(req_ready && (state != IDLE)))
                else $error("req_ready outside IDLE");
        end
    end

endmodule

// File: tb/tb_ram_access_master.sv
// tb_ram_access_master
// Directed bench for ram_access_master driving a small behavioural RAM. The
// RAM writes on any edge where ram_write is 1. It registers mem[ram_address]
// onto ram_out on any edge where ram_read is 1, which gives a one-edge read
// latency. Memory starts all zero.

module tb_ram_access_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_is_write;
    logic [7:0] rsp_rdata;
    logic       ram_read;
    logic       ram_write;
    logic [7:0] ram_address;
    logic [7:0] ram_data;
    logic [7:0] ram_out = 8'h00;

    logic [7:0] mem [0:255] = '{default: 8'h00};

    int vectors     = 0;
    int miscompares = 0;
    int overlap_cnt = 0;

    // clock / reset block
    always #5 clk = ~clk;

    ram_access_master #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .READ_LATENCY(1),
        .WRITE_HOLD  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_is_write(rsp_is_write),
        .rsp_rdata   (rsp_rdata),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_out     (ram_out)
    );

    // behavioural RAM
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
        if (ram_read)  ram_out <= mem[ram_address];
    end

    // Count any cycle where both strobes are high. test_back_to_back checks the count.
    always @(negedge clk) begin
        if (ram_read && ram_write) overlap_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [7:0] addr, input logic [7:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
    endtask

    task automatic clear_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_req();
        rsp_ready = 1'b0;
        do_reset();
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (ram_read !== 1'b0) begin miscompares++; $display("FAIL rst_ram_read: got %b want 0", ram_read); end
        vectors++; if (ram_write !== 1'b0) begin miscompares++; $display("FAIL rst_ram_write: got %b want 0", ram_write); end
        vectors++; if (ram_address !== 8'h00) begin miscompares++; $display("FAIL rst_ram_address: got %h want 00", ram_address); end
        vectors++; if (ram_data !== 8'h00) begin miscompares++; $display("FAIL rst_ram_data: got %h want 00", ram_data); end
        vectors++; if (rsp_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
        vectors++; if (rsp_is_write !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_is_write: got %b want 0", rsp_is_write); end
    endtask

    task automatic test_write();
        set_req(1'b1, 8'h01, 8'hAA);
        tick();                                   // accept edge E0
        clear_req();
        vectors++; if (ram_write !== 1'b1) begin miscompares++; $display("FAIL wr_strobe_on: got %b want 1", ram_write); end
        vectors++; if (ram_address !== 8'h01) begin miscompares++; $display("FAIL wr_address: got %h want 01", ram_address); end
        vectors++; if (ram_data !== 8'hAA) begin miscompares++; $display("FAIL wr_data: got %h want aa", ram_data); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL wr_req_ready_busy: got %b want 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); end
        tick();                                   // E0+1
        vectors++; if (ram_write !== 1'b0) begin miscompares++; $display("FAIL wr_strobe_off: got %b want 0", ram_write); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_is_write !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_is_write: got %b want 1", rsp_is_write); end
        vectors++; if (rsp_rdata !== 8'h00) begin miscompares++; $display("FAIL wr_rsp_rdata: got %h want 00", rsp_rdata); end
        rsp_ready = 1'b1;
        tick();                                   // handshake
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rsp_drop: got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_req_ready_back: got %b want 1", req_ready); end
        vectors++; if (mem[8'h01] !== 8'hAA) begin miscompares++; $display("FAIL wr_ram_content: got %h want aa", mem[8'h01]); end
    endtask

    task automatic test_read();
        set_req(1'b0, 8'h01, 8'h00);
        tick();                                   // E0
        clear_req();
        vectors++; if (ram_read !== 1'b1) begin miscompares++; $display("FAIL rd_strobe_e0: got %b want 1", ram_read); end
        vectors++; if (ram_write !== 1'b0) begin miscompares++; $display("FAIL rd_no_write: got %b want 0", ram_write); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rd_req_ready_busy: got %b want 0", req_ready); end
        tick();                                   // E0+1
        vectors++; if (ram_read !== 1'b1) begin miscompares++; $display("FAIL rd_strobe_e1: got %b want 1", ram_read); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_early: got %b want 0", rsp_valid); end
        tick();                                   // E0+2
        vectors++; if (ram_read !== 1'b0) begin miscompares++; $display("FAIL rd_strobe_off: got %b want 0", ram_read); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 8'hAA) begin miscompares++; $display("FAIL rd_rsp_rdata: got %h want aa", rsp_rdata); end
        vectors++; if (rsp_is_write !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_is_write: got %b want 0", rsp_is_write); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rd_req_ready_back: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        overlap_cnt = 0;
        rsp_ready = 1'b1;
        set_req(1'b1, 8'h0A, 8'hCC);
        tick();                                   // E0 write accept
        set_req(1'b0, 8'h0A, 8'h00);              // read waits behind the write
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_busy: got %b want 0", req_ready); end
        vectors++; if (ram_write !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_strobe: got %b want 1", ram_write); end
        tick();                                   // E0+1 RESP
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_resp_busy: got %b want 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_rsp: got %b want 1", rsp_valid); end
        tick();                                   // E0+2 handshake -> IDLE
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready: got %b want 1", req_ready); end
        vectors++; if (ram_read !== 1'b0) begin miscompares++; $display("FAIL b2b_read_early: got %b want 0", ram_read); end
        tick();                                   // E0+3 read accept
        clear_req();
        vectors++; if (ram_read !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_strobe: got %b want 1", ram_read); end
        vectors++; if (ram_address !== 8'h0A) begin miscompares++; $display("FAIL b2b_rd_address: got %h want 0a", ram_address); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_busy: got %b want 0", req_ready); end
        tick();                                   // E0+4
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_busy2: got %b want 0", req_ready); end
        tick();                                   // E0+5
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_rsp: got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 8'hCC) begin miscompares++; $display("FAIL b2b_rd_rdata: got %h want cc", rsp_rdata); end
        tick();                                   // E0+6 handshake
        rsp_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_final_ready: got %b want 1", req_ready); end
        vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL b2b_strobe_overlap: got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_unwritten_after_reset();
        do_reset();
        set_req(1'b0, 8'h1F, 8'h00);
        tick();
        clear_req();
        tick();
        tick();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL unw_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 8'h00) begin miscompares++; $display("FAIL unw_rsp_rdata: got %h want 00", rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        set_req(1'b0, 8'h01, 8'h00);
        tick();                                   // E0
        clear_req();
        tick();
        tick();                                   // response presented
        set_req(1'b1, 8'h33, 8'h55);              // must be ignored until handshake
        for (int i = 0; i < 5; i++) begin
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_rdata !== 8'hAA) begin miscompares++; $display("FAIL bp_rsp_rdata[%0d]: got %h want aa", i, rsp_rdata); end
            vectors++; if (ram_write !== 1'b0) begin miscompares++; $display("FAIL bp_ignored_req[%0d]: got %b want 0", i, ram_write); end
            vectors++; if (ram_address !== 8'h01) begin miscompares++; $display("FAIL bp_addr_hold[%0d]: got %h want 01", i, ram_address); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();                                   // handshake, pending request still waiting
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_drop: got %b want 0", rsp_valid); end
        vectors++; if (ram_write !== 1'b0) begin miscompares++; $display("FAIL bp_no_same_edge_accept: got %b want 0", ram_write); end
        tick();                                   // held request accepted now
        clear_req();
        vectors++; if (ram_write !== 1'b1) begin miscompares++; $display("FAIL bp_next_accept: got %b want 1", ram_write); end
        vectors++; if (ram_address !== 8'h33) begin miscompares++; $display("FAIL bp_next_addr: got %h want 33", ram_address); end
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        set_req(1'b0, 8'h01, 8'h00);
        tick();                                   // accept
        clear_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (ram_read !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ram_read: got %b want 0", ram_read); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_req_ready: got %b want 1", req_ready); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_late_rsp: got %b want 0", rsp_valid); end
        set_req(1'b0, 8'h01, 8'h00);
        tick();
        clear_req();
        tick();
        tick();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_rst_reread_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_rdata !== 8'hAA) begin miscompares++; $display("FAIL mid_rst_reread_data: got %h want aa", rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        clear_req();
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_unwritten_after_reset();
        test_backpressure();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
